// File: rtl/irq_id_arbiter_if.sv
// Handshake bundle between the event unit, the IRQ ID arbiter and the core.
// master = arbiter side, slave = event unit / core side.
interface irq_id_arbiter_if #(
    parameter int N_IRQ = 32
);
    logic [N_IRQ-1:0] irq_i;
    logic             irq_ack_i;
    logic             irq_req_o;
    logic [4:0]       irq_id_o;
    logic [N_IRQ-1:0] irq_clr_o;
    logic             busy_o;

    modport master (
        input  irq_i,
        input  irq_ack_i,
        output irq_req_o,
        output irq_id_o,
        output irq_clr_o,
        output busy_o
    );

    modport slave (
        output irq_i,
        output irq_ack_i,
        input  irq_req_o,
        input  irq_id_o,
        input  irq_clr_o,
        input  busy_o
    );
endinterface

// File: rtl/irq_id_arbiter.sv
// Picks one pending interrupt line, presents its ID to the core and pulses a clear on ack.
// Optional macro IRQ_ROUND_ROBIN_EN selects round-robin instead of lowest-index priority.
module irq_id_arbiter #(
    parameter int N_IRQ = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    irq_id_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t           state_r;
    logic             req_r;
    logic [4:0]       id_r;
    logic [N_IRQ-1:0] clr_r;
    logic             busy_r;

    logic [4:0]       winner_s;
    logic             any_s;
    logic             line_s;
    logic [N_IRQ-1:0] onehot_s;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [4:0]       ptr_r;

    // Round-robin search starting at the pointer, wrapping modulo N_IRQ.
    function automatic logic [4:0] rr_pick(input logic [N_IRQ-1:0] lines,
                                           input logic [4:0]       start);
        logic [4:0] win;
        logic       found;
        logic [5:0] idx;
        win   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            idx = 6'(start) + 6'(i);
            if (idx >= 6'(N_IRQ)) begin
                idx = idx - 6'(N_IRQ);
            end
            if (!found && lines[idx[4:0]]) begin
                win   = idx[4:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Winner selection from the current pointer.
    always_comb begin
        winner_s = rr_pick(bus.irq_i, ptr_r);
    end

    // Pointer moves past the serviced line only on an accepted ack.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr_r <= 5'd0;
        end else if (state_r == REQ && bus.irq_ack_i) begin
            ptr_r <= (id_r == 5'(N_IRQ - 1)) ? 5'd0 : id_r + 5'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: lowest set index wins.
    function automatic logic [4:0] low_pick(input logic [N_IRQ-1:0] lines);
        logic [4:0] win;
        logic       found;
        logic [4:0] idx;
        win   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            idx = 5'(i);
            if (!found && lines[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Winner selection with fixed priority.
    always_comb begin
        winner_s = low_pick(bus.irq_i);
    end
`endif

    // Helper terms: any line pending, level of the presented line, clear one-hot.
    always_comb begin
        any_s    = |bus.irq_i;
        line_s   = bus.irq_i[id_r];
        onehot_s = {{(N_IRQ - 1){1'b0}}, 1'b1} << id_r;
    end

    // Main request/ack FSM with registered outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            id_r    <= 5'd0;
            clr_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    clr_r <= '0;
                    if (any_s) begin
                        state_r <= REQ;
                        id_r    <= winner_s;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        id_r    <= id_r;
                        req_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                REQ: begin
                    id_r <= id_r;
                    // Ack wins over a simultaneous withdrawal.
                    if (bus.irq_ack_i) begin
                        state_r <= CLEAR;
                        req_r   <= 1'b0;
                        clr_r   <= onehot_s;
                        busy_r  <= 1'b1;
                    end else if (!line_s) begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                        clr_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= REQ;
                        req_r   <= 1'b1;
                        clr_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_r <= IDLE;
                    id_r    <= id_r;
                    req_r   <= 1'b0;
                    clr_r   <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    id_r    <= id_r;
                    req_r   <= 1'b0;
                    clr_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_req_o = req_r;
    assign bus.irq_id_o  = id_r;
    assign bus.irq_clr_o = clr_r;
    assign bus.busy_o    = busy_r;

endmodule

// File: tb/tb_irq_id_arbiter.sv
// Table-driven bench for irq_id_arbiter with a scoreboard queue and a reset corner sequence.
module tb_irq_id_arbiter;

    logic clk;
    logic rst_n;

    irq_id_arbiter_if #(.N_IRQ(32)) bus ();

    irq_id_arbiter #(.N_IRQ(32)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic [4:0]  RR_ID  = 5'd31;
    localparam logic [31:0] RR_CLR = 32'h8000_0000;
    localparam logic [4:0]  ID_C   = 5'd3;
`else
    localparam logic [4:0]  RR_ID  = 5'd0;
    localparam logic [31:0] RR_CLR = 32'h0000_0001;
    localparam logic [4:0]  ID_C   = 5'd2;
`endif

    typedef struct {
        string       name;
        logic [31:0] irq;
        logic        ack;
        logic        req;
        logic [4:0]  id;
        logic [31:0] clr;
        logic        busy;
    } vec_t;

    typedef struct {
        string       name;
        logic        req;
        logic [4:0]  id;
        logic [31:0] clr;
        logic        busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    task automatic add(input string n, input logic [31:0] irq, input logic ack,
                       input logic req, input logic [4:0] id, input logic [31:0] clr,
                       input logic busy);
        vec_t v;
        v.name = n; v.irq = irq; v.ack = ack;
        v.req = req; v.id = id; v.clr = clr; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check({e.name, ".req"},  {31'd0, bus.irq_req_o}, {31'd0, e.req});
        check({e.name, ".id"},   {27'd0, bus.irq_id_o},  {27'd0, e.id});
        check({e.name, ".clr"},  bus.irq_clr_o,          e.clr);
        check({e.name, ".busy"}, {31'd0, bus.busy_o},    {31'd0, e.busy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;

        //   name            irq            ack   req   id      clr            busy
        add("idle0",       32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0);
        add("rr_req0",     32'h8000_0001, 1'b0, 1'b1, 5'd0,  32'h0000_0000, 1'b1);
        add("rr_ack0",     32'h8000_0001, 1'b1, 1'b0, 5'd0,  32'h0000_0001, 1'b1);
        add("rr_clear0",   32'h8000_0001, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0);
        add("rr_req1",     32'h8000_0001, 1'b0, 1'b1, RR_ID, 32'h0000_0000, 1'b1);
        add("rr_ack1",     32'h8000_0001, 1'b1, 1'b0, RR_ID, RR_CLR,        1'b1);
        add("rr_clear1",   32'h0000_0000, 1'b0, 1'b0, RR_ID, 32'h0000_0000, 1'b0);
        add("rr_wrap",     32'h8000_0001, 1'b0, 1'b1, 5'd0,  32'h0000_0000, 1'b1);
        add("rr_withdraw", 32'h0000_0000, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b0);
        add("req_x14",     32'h0000_0014, 1'b0, 1'b1, 5'd2,  32'h0000_0000, 1'b1);
        add("hold_x14",    32'h0000_0014, 1'b0, 1'b1, 5'd2,  32'h0000_0000, 1'b1);
        add("ack_x14",     32'h0000_0014, 1'b1, 1'b0, 5'd2,  32'h0000_0004, 1'b1);
        add("clear_x14",   32'h0000_0010, 1'b0, 1'b0, 5'd2,  32'h0000_0000, 1'b0);
        add("idle_x14",    32'h0000_0000, 1'b0, 1'b0, 5'd2,  32'h0000_0000, 1'b0);
        add("ack_idle",    32'h0000_0000, 1'b1, 1'b0, 5'd2,  32'h0000_0000, 1'b0);
        add("req_b5",      32'h0000_0020, 1'b0, 1'b1, 5'd5,  32'h0000_0000, 1'b1);
        add("withdraw_b5", 32'h0000_0000, 1'b0, 1'b0, 5'd5,  32'h0000_0000, 1'b0);
        add("ptr_kept",    32'h0000_000C, 1'b0, 1'b1, ID_C,  32'h0000_0000, 1'b1);
        add("withdraw_c",  32'h0000_0000, 1'b0, 1'b0, ID_C,  32'h0000_0000, 1'b0);
        add("req_b5b",     32'h0000_0020, 1'b0, 1'b1, 5'd5,  32'h0000_0000, 1'b1);
        add("drop_ack_b5", 32'h0000_0000, 1'b1, 1'b0, 5'd5,  32'h0000_0020, 1'b1);
        add("clear_b5",    32'h0000_0000, 1'b1, 1'b0, 5'd5,  32'h0000_0000, 1'b0);
        add("req_x300",    32'h0000_0300, 1'b0, 1'b1, 5'd8,  32'h0000_0000, 1'b1);
        add("hold_x3c0",   32'h0000_03C0, 1'b0, 1'b1, 5'd8,  32'h0000_0000, 1'b1);
        add("ack_x100",    32'h0000_0100, 1'b1, 1'b0, 5'd8,  32'h0000_0100, 1'b1);
        add("clear_x100",  32'h0000_0000, 1'b0, 1'b0, 5'd8,  32'h0000_0000, 1'b0);

        rst_n         = 1'b0;
        bus.irq_i     = 32'h0000_0000;
        bus.irq_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e.name = "reset"; e.req = 1'b0; e.id = 5'd0; e.clr = 32'h0000_0000; e.busy = 1'b0;
        check_outputs(e);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.irq_i     = vecs[i].irq;
            bus.irq_ack_i = vecs[i].ack;
            e.name = vecs[i].name; e.req = vecs[i].req; e.id = vecs[i].id;
            e.clr  = vecs[i].clr;  e.busy = vecs[i].busy;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs(e);
        end

        // Asynchronous reset while a request is outstanding.
        bus.irq_i     = 32'h0000_0040;
        bus.irq_ack_i = 1'b0;
        @(posedge clk);
        #1;
        e.name = "pre_reset"; e.req = 1'b1; e.id = 5'd6; e.clr = 32'h0000_0000; e.busy = 1'b1;
        check_outputs(e);
        #3;
        rst_n = 1'b0;
        #1;
        e.name = "async_reset"; e.req = 1'b0; e.id = 5'd0; e.clr = 32'h0000_0000; e.busy = 1'b0;
        check_outputs(e);
        @(posedge clk);
        #1;
        e.name = "held_reset";
        check_outputs(e);
        bus.irq_i = 32'h0000_0008;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        e.name = "post_reset"; e.req = 1'b1; e.id = 5'd3; e.clr = 32'h0000_0000; e.busy = 1'b1;
        check_outputs(e);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/irq_id_arbiter.md
IRQ_ID_ARBITER -- requirements
Module: irq_id_arbiter

Interface
REQ-001 The module SHALL have parameter N_IRQ, default 32, giving the number of interrupt lines; legal range 2..32.
REQ-002 The module SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port HRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port irq_i, input, N_IRQ bits: level interrupt lines from the event unit (pending AND mask).
REQ-005 The module SHALL have port irq_ack_i, input, 1 bit: core accepts the request presented on irq_id_o.
REQ-006 The module SHALL have port irq_req_o, output, 1 bit: interrupt request to the core.
REQ-007 The module SHALL have port irq_id_o, output, 5 bits: index of the requested line.
REQ-008 The module SHALL have port irq_clr_o, output, N_IRQ bits: one-hot, one-cycle pulse that clears the serviced pending bit upstream.
REQ-009 The module SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, REQ and CLEAR.
REQ-011 In IDLE with irq_i != 0 at edge N, the FSM SHALL latch the winner into irq_id_o and enter REQ; irq_req_o SHALL be high from cycle N+1.
REQ-012 Without IRQ_ROUND_ROBIN_EN, the winner SHALL be the lowest set index of irq_i.
REQ-013 In REQ, irq_id_o SHALL stay stable and irq_req_o SHALL stay high until ack or withdrawal.
REQ-014 In REQ, irq_ack_i=1 SHALL drive irq_clr_o[irq_id_o]=1 for exactly the next cycle and move the FSM to CLEAR, with irq_req_o low in that cycle.
REQ-015 In REQ, if irq_i[irq_id_o]=0 and irq_ack_i=0 (withdrawal), the FSM SHALL return to IDLE, deassert irq_req_o and emit no clear.
REQ-016 If withdrawal and irq_ack_i=1 occur in the same cycle, the ack SHALL take precedence (REQ-014 applies).
REQ-017 CLEAR SHALL last exactly one cycle and then go to IDLE, so the upstream level has one cycle to drop; no new request SHALL be issued in CLEAR.
REQ-018 irq_ack_i SHALL be ignored in IDLE and CLEAR.
REQ-019 irq_clr_o SHALL be all-zero except during the single cycle after an accepted ack.
REQ-020 Bits of irq_i changing while in REQ SHALL NOT alter irq_id_o.
REQ-021 irq_id_o SHALL hold its last value in IDLE and CLEAR.

Reset
REQ-022 On HRESETn low, the module SHALL asynchronously force FSM=IDLE, irq_req_o=0, irq_id_o=0, irq_clr_o=0, busy_o=0, and set the round-robin pointer to 0.
REQ-023 Reset asserted mid-REQ SHALL drop irq_req_o immediately, with no clear pulse emitted.
REQ-024 After reset release, the first request SHALL follow REQ-011 timing.

Configuration
REQ-025 Macro IRQ_ROUND_ROBIN_EN, when defined, SHALL select round-robin arbitration: search starts at pointer p (reset 0); winner = first set index at or above p, wrapping modulo N_IRQ.
REQ-026 With IRQ_ROUND_ROBIN_EN, the pointer p SHALL be updated to (serviced id + 1) mod N_IRQ on each accepted ack; withdrawal SHALL leave p unchanged; id N_IRQ-1 SHALL wrap p to 0.
REQ-027 Without IRQ_ROUND_ROBIN_EN, fixed lowest-index priority (REQ-012) SHALL apply and no pointer register SHALL exist.

Verification
REQ-028 The bench SHALL drive irq_i=0x0000_0014 in IDLE -> irq_req_o=1 and irq_id_o=2 one cycle later; ack -> irq_clr_o=0x0000_0004 for one cycle; CLEAR, then IDLE.
REQ-029 The bench SHALL raise irq_i bit 5 then drop it before ack -> irq_req_o falls, irq_clr_o stays 0, FSM is IDLE.
REQ-030 The bench SHALL apply drop of bit 5 and ack in the same cycle -> irq_clr_o=0x0000_0020 (ack wins).
REQ-031 The bench SHALL hold irq_i=0x8000_0001 through two services with IRQ_ROUND_ROBIN_EN -> ids 0 then 31, pointer wraps to 0; without the macro -> id 0 both times.
REQ-032 The bench SHALL assert HRESETn low while in REQ -> all outputs 0 asynchronously; after release with irq_i=0x8 -> id 3 one cycle later.
REQ-033 The bench SHALL pulse irq_ack_i in IDLE -> no clear pulse and no state change.
